div_step_sequencer: RTL

Step sequencer that drives the `div_clock` ratio input of the multi-output clock divider from a programmable table of divisor/dwell pairs. It counts rising edges of the divider's `div_var` output and, at each step boundary, loads the next divisor, so the variable-rate clock follows a programmed tempo/pitch pattern. It sits between the control/register logic and the divider, in the divider's clock domain.

---
 rtl/div_seq_pkg.sv | 25 ++
 rtl/div_step_sequencer_if.sv | 37 +++
 rtl/div_seq_table.sv | 55 +++++
 rtl/div_step_sequencer.sv | 118 +++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// Shared types and constants for the divider step sequencer.
//   state_t       : sequencer FSM states
//   DIV_DEFAULT   : divisor held by every table entry after reset
//   DWELL_DEFAULT : dwell held by every table entry after reset
//   entry_t       : one table entry {div, dwell} at the default widths
package div_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIV_DEFAULT   = 1;
    localparam int DWELL_DEFAULT = 1;

    localparam int ENTRY_DIV_W   = 12;
    localparam int ENTRY_DWELL_W = 8;

    typedef struct packed {
        logic [ENTRY_DIV_W-1:0]   div;
        logic [ENTRY_DWELL_W-1:0] dwell;
    } entry_t;

endpackage

// File: rtl/div_step_sequencer_if.sv
// Bundle between the control/register side and the step sequencer.
//   master : control side (table writes, pattern control, div_var feed)
//   slave  : sequencer (drives div_clock, step_idx, step_strobe, busy, done)
interface div_step_sequencer_if #(
    parameter int DEPTH   = 8,
    parameter int DIV_W   = 12,
    parameter int DWELL_W = 8
) ();
    localparam int IDX_W = $clog2(DEPTH);

    logic               wr_en;
    logic [IDX_W-1:0]   wr_addr;
    logic [DIV_W-1:0]   wr_div;
    logic [DWELL_W-1:0] wr_dwell;
    logic [IDX_W-1:0]   last_idx;
    logic               loop_en;
    logic               start;
    logic               stop;
    logic               div_var_in;
    logic [DIV_W-1:0]   div_clock;
    logic [IDX_W-1:0]   step_idx;
    logic               step_strobe;
    logic               busy;
    logic               done;

    modport master (
        output wr_en, wr_addr, wr_div, wr_dwell, last_idx, loop_en,
               start, stop, div_var_in,
        input  div_clock, step_idx, step_strobe, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_div, wr_dwell, last_idx, loop_en,
               start, stop, div_var_in,
        output div_clock, step_idx, step_strobe, busy, done
    );
endinterface

// File: rtl/div_seq_table.sv
// Divisor/dwell table: DEPTH entries, one write port with zero clamping,
// one asynchronous read port. Entries return to {1,1} on reset.
//   clk, reset         : clock, async active-high reset
//   wr_en/addr/div/dwell : write port
//   rd_addr            : read index
//   rd_div, rd_dwell   : entry at rd_addr (pre-write value in a write cycle)
module div_seq_table
    import div_seq_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DIV_W   = 12,
    parameter int DWELL_W = 8,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_addr,
    input  logic [DIV_W-1:0]   wr_div,
    input  logic [DWELL_W-1:0] wr_dwell,
    input  logic [IDX_W-1:0]   rd_addr,
    output logic [DIV_W-1:0]   rd_div,
    output logic [DWELL_W-1:0] rd_dwell
);
    logic [DIV_W-1:0]   div_q   [DEPTH];
    logic [DIV_W-1:0]   div_d   [DEPTH];
    logic [DWELL_W-1:0] dwell_q [DEPTH];
    logic [DWELL_W-1:0] dwell_d [DEPTH];

    // A zero divisor would stall the divider and a zero dwell would never
    // terminate, so both are stored as the default instead.
    always_comb begin
        div_d   = div_q;
        dwell_d = dwell_q;
        if (wr_en) begin
            div_d[wr_addr]   = (wr_div == '0)   ? DIV_W'(DIV_DEFAULT)     : wr_div;
            dwell_d[wr_addr] = (wr_dwell == '0) ? DWELL_W'(DWELL_DEFAULT) : wr_dwell;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                div_q[i]   <= DIV_W'(DIV_DEFAULT);
                dwell_q[i] <= DWELL_W'(DWELL_DEFAULT);
            end
        end else begin
            div_q   <= div_d;
            dwell_q <= dwell_d;
        end
    end

    assign rd_div   = div_q[rd_addr];
    assign rd_dwell = dwell_q[rd_addr];
endmodule

// File: rtl/div_step_sequencer.sv
// Step sequencer feeding the clock divider's div_clock ratio from a table
// of divisor/dwell pairs, advancing on counted div_var rising edges.
//   clk, reset : divider clock, async active-high reset
//   bus        : control inputs, table writes, div_var feed and status
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold last values
//   RUN   | counting div_var edges through the active step
//   DONE  | pattern finished without looping; done=1
module div_step_sequencer
    import div_seq_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DIV_W   = 12,
    parameter int DWELL_W = 8,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    div_step_sequencer_if.slave    bus
);
    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_clock_q, div_clock_d;
    logic [IDX_W-1:0]   step_idx_q, step_idx_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic               step_strobe_q, step_strobe_d;
    logic               div_var_q;

    logic               div_edge;
    logic               load;
    logic [IDX_W-1:0]   rd_addr;
    logic [DIV_W-1:0]   rd_div;
    logic [DWELL_W-1:0] rd_dwell;

    div_seq_table #(
        .DEPTH   (DEPTH),
        .DIV_W   (DIV_W),
        .DWELL_W (DWELL_W)
    ) u_table (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .wr_div   (bus.wr_div),
        .wr_dwell (bus.wr_dwell),
        .rd_addr  (rd_addr),
        .rd_div   (rd_div),
        .rd_dwell (rd_dwell)
    );

    assign div_edge = bus.div_var_in & ~div_var_q;

    // Priority: stop, then start (which masks a coincident edge), then
    // edge-driven advance in RUN. All step loads share one path so the
    // table read index and the new step_idx always agree.
    always_comb begin
        state_d       = state_q;
        div_clock_d   = div_clock_q;
        step_idx_d    = step_idx_q;
        dwell_cnt_d   = dwell_cnt_q;
        step_strobe_d = 1'b0;
        load          = 1'b0;
        rd_addr       = '0;

        if (bus.stop) begin
            state_d     = IDLE;
            dwell_cnt_d = '0;
        end else if (bus.start) begin
            load = 1'b1;
        end else if (state_q == RUN && div_edge) begin
            if (dwell_cnt_q == DWELL_W'(1)) begin
                if (step_idx_q != bus.last_idx) begin
                    load    = 1'b1;
                    rd_addr = IDX_W'(step_idx_q + 1'b1);
                end else if (bus.loop_en) begin
                    load = 1'b1;
                end else begin
                    state_d     = DONE;
                    dwell_cnt_d = '0;
                end
            end else begin
                dwell_cnt_d = dwell_cnt_q - 1'b1;
            end
        end

        if (load) begin
            state_d       = RUN;
            div_clock_d   = rd_div;
            dwell_cnt_d   = rd_dwell;
            step_idx_d    = rd_addr;
            step_strobe_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            div_clock_q   <= DIV_W'(DIV_DEFAULT);
            step_idx_q    <= '0;
            dwell_cnt_q   <= '0;
            step_strobe_q <= 1'b0;
            div_var_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_clock_q   <= div_clock_d;
            step_idx_q    <= step_idx_d;
            dwell_cnt_q   <= dwell_cnt_d;
            step_strobe_q <= step_strobe_d;
            div_var_q     <= bus.div_var_in;
        end
    end

    assign bus.div_clock   = div_clock_q;
    assign bus.step_idx    = step_idx_q;
    assign bus.step_strobe = step_strobe_q;
    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
endmodule
